// File: rtl/clock_division_pkg.sv
// rtl/clock_division_pkg.sv - shared modes, limits and elaboration checks for the clock divider
package clock_division_pkg;

    typedef enum logic {
        MODE_SQUARE = 1'b0,
        MODE_TICK   = 1'b1
    } mode_e;

    localparam int MIN_WIDTH    = 2;
    localparam int MAX_WIDTH    = 30;
    localparam int MIN_CHANNELS = 1;
    localparam int MAX_CHANNELS = 16;

    function automatic bit width_ok(input int width);
        return (width >= MIN_WIDTH) && (width <= MAX_WIDTH);
    endfunction

    function automatic bit channels_ok(input int channels);
        return (channels >= MIN_CHANNELS) && (channels <= MAX_CHANNELS);
    endfunction

endpackage

// File: rtl/clock_division_channel.sv
// rtl/clock_division_channel.sv - one divider channel: counter, active/shadow settings, output flop
module clock_division_channel
    import clock_division_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int RESET_PERIOD = 2,
    parameter int RESET_HIGH   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             load,
    input  logic             sync,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] high,
    input  logic             mode,
    output logic             div_clock,
    output logic             pending
);

    typedef struct packed {
        logic [WIDTH-1:0] period;
        logic [WIDTH-1:0] high;
        mode_e            mode;
    } settings_t;

    localparam settings_t RESET_SET = '{
        period: WIDTH'(RESET_PERIOD),
        high:   WIDTH'(RESET_HIGH),
        mode:   MODE_SQUARE
    };

    function automatic logic [WIDTH-1:0] eff_period(input logic [WIDTH-1:0] p, input mode_e m);
        if (m == MODE_TICK)
            return (p == '0) ? WIDTH'(1) : p;
        return (p < WIDTH'(2)) ? WIDTH'(2) : p;
    endfunction

    // Pe >= 2 in square mode, so Pe-1 never underflows.
    function automatic logic [WIDTH-1:0] eff_high(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] pe);
        if (h == '0)
            return WIDTH'(1);
        if (h > pe - WIDTH'(1))
            return pe - WIDTH'(1);
        return h;
    endfunction

    settings_t        act, shd;
    logic [WIDTH-1:0] cnt;
    logic             running;

    settings_t        in_set, act_next, shd_next;
    logic [WIDTH-1:0] cnt_next, pe_cur, pe_next, he_next;
    logic             pend_next, clk_next, boundary;

    always_comb begin
        in_set    = '{period: period, high: high, mode: mode_e'(mode)};
        act_next  = act;
        shd_next  = shd;
        pend_next = pending;
        cnt_next  = cnt;
        clk_next  = 1'b0;
        pe_cur    = eff_period(act.period, act.mode);
        boundary  = !running || sync || (cnt == pe_cur - WIDTH'(1));

        if (!enable) begin
            cnt_next = '0;
            if (pending) begin
                act_next  = shd;
                pend_next = 1'b0;
            end
            if (load) begin
                shd_next  = in_set;
                pend_next = 1'b1;
            end
        end else if (boundary) begin
            cnt_next = '0;
            if (sync && load) begin
                act_next  = in_set;
                shd_next  = in_set;
                pend_next = 1'b0;
            end else begin
                if (pending)
                    act_next = shd;
                pend_next = 1'b0;
                // A load on a wrap edge waits for the following wrap.
                if (load) begin
                    shd_next  = in_set;
                    pend_next = 1'b1;
                end
            end
        end else begin
            cnt_next = cnt + WIDTH'(1);
            if (load) begin
                shd_next  = in_set;
                pend_next = 1'b1;
            end
        end

        pe_next = eff_period(act_next.period, act_next.mode);
        he_next = eff_high(act_next.high, pe_next);
        if (enable) begin
            if (act_next.mode == MODE_TICK)
                clk_next = (cnt_next == pe_next - WIDTH'(1));
            else
                clk_next = (cnt_next < he_next);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act       <= RESET_SET;
            shd       <= RESET_SET;
            cnt       <= '0;
            running   <= 1'b0;
            pending   <= 1'b0;
            div_clock <= 1'b0;
        end else begin
            act       <= act_next;
            shd       <= shd_next;
            cnt       <= cnt_next;
            running   <= enable;
            pending   <= pend_next;
            div_clock <= clk_next;
        end
    end

endmodule

// File: rtl/clock_division_multi.sv
// rtl/clock_division_multi.sv - multi-channel programmable clock/tick divider top
module clock_division_multi
    import clock_division_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int WIDTH        = 8,
    parameter int RESET_PERIOD = 2,
    parameter int RESET_HIGH   = 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic [CHANNELS-1:0]       i_enable,
    input  logic [CHANNELS-1:0]       i_load,
    input  logic [CHANNELS*WIDTH-1:0] i_period,
    input  logic [CHANNELS*WIDTH-1:0] i_high,
    input  logic [CHANNELS-1:0]       i_mode,
    input  logic                      i_sync,
    output logic [CHANNELS-1:0]       o_clock,
    output logic [CHANNELS-1:0]       o_pending
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("clock_division_multi: WIDTH out of range");
    end
    if (!channels_ok(CHANNELS)) begin : g_bad_channels
        $error("clock_division_multi: CHANNELS out of range");
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        clock_division_channel #(
            .WIDTH        (WIDTH),
            .RESET_PERIOD (RESET_PERIOD),
            .RESET_HIGH   (RESET_HIGH)
        ) u_channel (
            .clk       (i_clock),
            .rst_n     (i_reset_n),
            .enable    (i_enable[c]),
            .load      (i_load[c]),
            .sync      (i_sync),
            .period    (i_period[c*WIDTH +: WIDTH]),
            .high      (i_high[c*WIDTH +: WIDTH]),
            .mode      (i_mode[c]),
            .div_clock (o_clock[c]),
            .pending   (o_pending[c])
        );
    end

endmodule
